// File: rtl/kamus_id_stage.sv
// kamus_id_stage: instruction-decode stage.
// A DEPTH-entry FIFO decouples fetch from issue. The FIFO head is decoded,
// its register operands are read with writeback bypass, and the decoded
// result is registered into a single ID/EX slot. A load-use hazard holds the
// head in the FIFO. A saturating counter records the cycles lost to it.
module kamus_id_stage #(
  parameter int XLEN      = 32,
  parameter int PC_WIDTH  = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 if_valid_i,
  output logic                 if_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [PC_WIDTH-1:0]  instr_addr_i,
  input  logic [PC_WIDTH-1:0]  next_pc_i,
  output logic [4:0]           rs1_addr_o,
  output logic [4:0]           rs2_addr_o,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  input  logic                 wb_en_i,
  input  logic [4:0]           wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic                 ex_load_pending_i,
  input  logic [4:0]           ex_load_rd_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [6:0]           ex_opcode_o,
  output logic [2:0]           ex_funct3_o,
  output logic [6:0]           ex_funct7_o,
  output logic [4:0]           ex_rd_o,
  output logic [XLEN-1:0]      ex_imm_o,
  output logic                 ex_imm_used_o,
  output logic                 ex_illegal_o,
  output logic [XLEN-1:0]      ex_rs1_data_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [PC_WIDTH-1:0]  ex_pc_o,
  output logic [PC_WIDTH-1:0]  ex_next_pc_o,
  output logic [CNT_WIDTH-1:0] hazard_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FILL_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   FILL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = (PTR_W)'(1);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Operand select: x0 reads as zero, and a same-cycle writeback overrides the register file.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] res;
    if (addr == 5'd0) begin
      res = {XLEN{1'b0}};
    end else if (wb_en && (wb_rd == addr)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // FIFO storage and pointers
  logic [31:0]         fifo_instr_q [DEPTH];
  logic [PC_WIDTH-1:0] fifo_addr_q  [DEPTH];
  logic [PC_WIDTH-1:0] fifo_npc_q   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      fill_q, fill_d;

  logic push_s, pop_s, head_valid_s;
  logic [31:0] head_instr_s;

  // Decode results of the head
  logic [6:0]      op_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [31:0]     imm32_s;
  logic [XLEN-1:0] imm_s;
  logic            imm_used_s, illegal_s, rs1_used_s, rs2_used_s;

  logic hazard_s, slot_free_s, issue_s;

  // ID/EX slot
  logic                 ex_valid_q;
  logic [6:0]           ex_opcode_q, ex_funct7_q;
  logic [2:0]           ex_funct3_q;
  logic [4:0]           ex_rd_q;
  logic [XLEN-1:0]      ex_imm_q, ex_rs1_q, ex_rs2_q;
  logic                 ex_imm_used_q, ex_illegal_q;
  logic [PC_WIDTH-1:0]  ex_pc_q, ex_npc_q;
  logic [CNT_WIDTH-1:0] hazard_cnt_q;

  // Ready depends only on occupancy, so there is no path from ex_ready_i to fetch.
  assign if_ready_o   = ~rst_i & (fill_q != FILL_FULL);
  assign push_s       = if_valid_i & if_ready_o;
  assign pop_s        = issue_s;
  assign head_valid_s = (fill_q != {(PTR_W+1){1'b0}});
  assign head_instr_s = fifo_instr_q[rd_ptr_q];

  assign op_s       = head_instr_s[6:0];
  assign f3_s       = head_instr_s[14:12];
  assign f7_s       = head_instr_s[31:25];
  assign rs1_addr_o = head_instr_s[19:15];
  assign rs2_addr_o = head_instr_s[24:20];

  // Next-state of FIFO pointers and fill level; flush empties the FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      fill_d   = {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
    end
  end

  // FIFO pointer and fill registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      fill_q   <= {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // FIFO payload write; a push coinciding with flush is dropped.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i) begin
      fifo_instr_q[wr_ptr_q] <= instr_i;
      fifo_addr_q[wr_ptr_q]  <= instr_addr_i;
      fifo_npc_q[wr_ptr_q]   <= next_pc_i;
    end
  end

  // Decode the head: immediate format, legality and register usage.
  always_comb begin
    imm32_s    = 32'h0000_0000;
    imm_used_s = 1'b0;
    illegal_s  = 1'b0;
    rs1_used_s = 1'b1;
    rs2_used_s = 1'b0;
    case (op_s)
      OPC_LUI, OPC_AUIPC: begin
        imm32_s    = {head_instr_s[31:12], 12'h000};
        imm_used_s = 1'b1;
        rs1_used_s = 1'b0;
      end
      OPC_JAL: begin
        imm32_s    = {{11{head_instr_s[31]}}, head_instr_s[31], head_instr_s[19:12],
                      head_instr_s[20], head_instr_s[30:21], 1'b0};
        imm_used_s = 1'b1;
        rs1_used_s = 1'b0;
      end
      OPC_JALR: begin
        imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
        imm_used_s = 1'b1;
      end
      OPC_BRANCH: begin
        imm32_s    = {{19{head_instr_s[31]}}, head_instr_s[31], head_instr_s[7],
                      head_instr_s[30:25], head_instr_s[11:8], 1'b0};
        imm_used_s = 1'b1;
        rs2_used_s = 1'b1;
        illegal_s  = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OPC_LOAD: begin
        imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
        imm_used_s = 1'b1;
        illegal_s  = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      end
      OPC_STORE: begin
        imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[31:25], head_instr_s[11:7]};
        imm_used_s = 1'b1;
        rs2_used_s = 1'b1;
        illegal_s  = (f3_s > 3'b010);
      end
      OPC_OP_IMM: begin
        imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
        imm_used_s = 1'b1;
        illegal_s  = ((f3_s == 3'b001) || (f3_s == 3'b101)) && head_instr_s[25];
      end
      OPC_OP: begin
        rs2_used_s = 1'b1;
        if (f7_s == 7'b0000000) begin
          illegal_s = 1'b0;
        end else if (f7_s == 7'b0100000) begin
          // Only SUB and SRA carry the alternate funct7.
          illegal_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        illegal_s = 1'b0;
      end
      OPC_SYSTEM: begin
        imm32_s    = {27'd0, head_instr_s[19:15]};
        imm_used_s = f3_s[2];
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    if (head_instr_s[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
  end

  assign imm_s = XLEN'($signed(imm32_s));

  assign hazard_s = head_valid_s & ex_load_pending_i & (ex_load_rd_i != 5'd0) &
                    ((rs1_used_s & (rs1_addr_o == ex_load_rd_i)) |
                     (rs2_used_s & (rs2_addr_o == ex_load_rd_i)));
  assign slot_free_s = ~ex_valid_q | ex_ready_i;
  assign issue_s     = head_valid_s & ~hazard_s & slot_free_s;

  // ID/EX slot: load on issue, empty when consumed with nothing to issue, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q    <= 1'b0;
      ex_opcode_q   <= 7'd0;
      ex_funct3_q   <= 3'd0;
      ex_funct7_q   <= 7'd0;
      ex_rd_q       <= 5'd0;
      ex_imm_q      <= {XLEN{1'b0}};
      ex_imm_used_q <= 1'b0;
      ex_illegal_q  <= 1'b0;
      ex_rs1_q      <= {XLEN{1'b0}};
      ex_rs2_q      <= {XLEN{1'b0}};
      ex_pc_q       <= {PC_WIDTH{1'b0}};
      ex_npc_q      <= {PC_WIDTH{1'b0}};
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (issue_s) begin
      ex_valid_q    <= 1'b1;
      ex_opcode_q   <= op_s;
      ex_funct3_q   <= f3_s;
      ex_funct7_q   <= f7_s;
      ex_rd_q       <= head_instr_s[11:7];
      ex_imm_q      <= imm_s;
      ex_imm_used_q <= imm_used_s;
      ex_illegal_q  <= illegal_s;
      ex_rs1_q      <= pick_operand(rs1_addr_o, rs1_data_i, wb_en_i, wb_rd_i, wb_data_i);
      ex_rs2_q      <= pick_operand(rs2_addr_o, rs2_data_i, wb_en_i, wb_rd_i, wb_data_i);
      ex_pc_q       <= fifo_addr_q[rd_ptr_q];
      ex_npc_q      <= fifo_npc_q[rd_ptr_q];
    end else if (slot_free_s) begin
      ex_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_q;
    end
  end

  // Saturating count of cycles where a free slot was lost to a load-use hazard; survives flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hazard_cnt_q <= {CNT_WIDTH{1'b0}};
    end else if (hazard_s && slot_free_s && !(&hazard_cnt_q)) begin
      hazard_cnt_q <= hazard_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      hazard_cnt_q <= hazard_cnt_q;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_opcode_o   = ex_opcode_q;
  assign ex_funct3_o   = ex_funct3_q;
  assign ex_funct7_o   = ex_funct7_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_imm_used_o = ex_imm_used_q;
  assign ex_illegal_o  = ex_illegal_q;
  assign ex_rs1_data_o = ex_rs1_q;
  assign ex_rs2_data_o = ex_rs2_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_next_pc_o  = ex_npc_q;
  assign hazard_cnt_o  = hazard_cnt_q;

endmodule

// File: doc/kamus_id_stage.md
# kamus_id_stage

Registered, parametrised instruction-decode stage between `kamus_IF` and EX. It buffers fetched instructions in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It decodes the FIFO head into fields, sign-extended immediate and illegal flag, and reads the register file. It detects load-use hazards and forwards same-cycle writeback. Results are presented in a registered ID/EX slot.

## Interface
- `XLEN`, 32, data/immediate width.
- `PC_WIDTH`, 32, address width.
- `DEPTH`, 2, FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 16, width of hazard-stall counter.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset. Synchronous and active-high.
- `flush_i` in 1: discard all buffered and staged instructions.
- `if_valid_i` in 1, `if_ready_o` out 1: fetch handshake.
- `instr_i` in 32, `instr_addr_i` in PC_WIDTH, `next_pc_i` in PC_WIDTH: fetch payload.
- `rs1_addr_o`, `rs2_addr_o` out 5: register-file read addresses, combinational from the FIFO head.
- `rs1_data_i`, `rs2_data_i` in XLEN: register-file read data, same cycle.
- `wb_en_i` in 1, `wb_rd_i` in 5, `wb_data_i` in XLEN: writeback port, used for bypass.
- `ex_load_pending_i` in 1, `ex_load_rd_i` in 5: load in EX whose data is not yet available.
- `ex_valid_o` out 1, `ex_ready_i` in 1: EX handshake.
- `ex_opcode_o` out 7, `ex_funct3_o` out 3, `ex_funct7_o` out 7, `ex_rd_o` out 5: decoded fields.
- `ex_imm_o` out XLEN, `ex_imm_used_o` out 1, `ex_illegal_o` out 1: immediate and legality.
- `ex_rs1_data_o`, `ex_rs2_data_o` out XLEN: operand data.
- `ex_pc_o`, `ex_next_pc_o` out PC_WIDTH: addresses.
- `hazard_cnt_o` out CNT_WIDTH: saturating count of hazard-stall cycles.

## Operation
**FIFO**
- Stores {instr, addr, next_pc}.
- Push when `if_valid_i && if_ready_o`.
- `if_ready_o = !full`. It depends on occupancy only; there is no combinational path from `ex_ready_i`.
- Pop happens on issue. Push and pop in the same cycle keep the count unchanged.
- Pointers wrap modulo DEPTH.

**Decode of the head (combinational)**
- Immediate by opcode type:
  - I-type (JALR/LOAD/OP-IMM): {sext, instr[31:20]}
  - S-type: {sext, [31:25], [11:7]}
  - B-type: {sext, [7], [30:25], [11:8], 0}
  - J-type: {sext, [19:12], [20], [30:21], 0}
  - U-type (LUI/AUIPC): {[31:12], 12'b0}
  - SYSTEM: zero-extended zimm [19:15], with `imm_used = funct3[2]`
  - All other opcodes: imm = 0, `imm_used = 0`.
- Sign extension replicates `instr[31]` to XLEN.
- `illegal` is set for any of:
  - `instr[1:0] != 2'b11`
  - an unknown opcode
  - branch funct3 of 010 or 011
  - load funct3 of 011, 110 or 111
  - store funct3 > 010
  - OP-IMM shift with `instr[25]=1`
  - OP with funct7 other than 0000000 or 0100000 (the latter valid only for ADD/SUB and SRL/SRA)
- Illegal instructions still issue, with `ex_illegal_o=1`.

**Register usage**
- rs1 is used by every type except LUI, AUIPC and JAL.
- rs2 is used by OP, STORE and BRANCH.

**Hazard and issue**
- `hazard` = head valid && `ex_load_pending_i` && `ex_load_rd_i != 0` && (rs1 used && rs1 == rd, or rs2 used && rs2 == rd).
- The output slot is free when `!ex_valid_o || ex_ready_i`.
- `issue` = head valid && !hazard && slot free.

**Slot update**
- On issue the slot loads the decoded head and sets `ex_valid_o=1`.
- If the slot is free and there is no issue, `ex_valid_o` goes to 0.
- Otherwise the slot holds.

**Writeback bypass**
- At issue, if `wb_en_i && wb_rd_i != 0 && wb_rd_i == rsN`, the slot captures `wb_data_i` instead of `rsN_data_i`.
- Register x0 data is always captured as 0.

**Hazard counter**
- Increments on each cycle where hazard && slot free.
- Saturates at all-ones.
- It is not cleared by flush.

**Priority:** reset > flush > normal operation.

## Timing
- **Reset** (synchronous):
  - FIFO count = 0, `ex_valid_o=0`, all `ex_*` data outputs = 0, `hazard_cnt_o=0`.
  - `if_ready_o=0` while `rst_i=1`, and 1 on the first cycle after reset.
  - Reset asserted mid-stream drops all contents.
- **Latency:** an instruction pushed in cycle N into an empty FIFO with a free slot appears on `ex_valid_o` in cycle N+2 (FIFO write, then slot register).
- **Throughput:** 1 instruction/cycle with no hazards and `ex_ready_i=1`.
- **Holding:** `ex_*` payload is stable while `ex_valid_o && !ex_ready_i`.
- **Flush:**
  - In the cycle after `flush_i`: count = 0 and `ex_valid_o=0`.
  - A push in the flush cycle is discarded.
  - `if_ready_o` stays high during flush unless the FIFO is full.
- **Hazard stall:**
  - The head is held and `ex_valid_o` drops after EX consumes the previous slot.
  - The instruction issues in the cycle `ex_load_pending_i` deasserts.
- **Full FIFO:** `if_ready_o=0`. A simultaneous pop does not re-enable push until the next cycle.

## Test plan
- **Stream:** push ADDI x1,x0,-5 (0xFFB00093), ADD, SUB, LUI x2,0x12345 with `ex_ready_i=1`.
  - ADDI: `ex_imm_o=0xFFFFFFFB`, `ex_imm_used_o=1`.
  - LUI: `ex_imm_o=0x12345000`.
  - Four valid outputs in consecutive cycles starting at N+2.
- **Backpressure:** hold `ex_ready_i=0` for 6 cycles while pushing.
  - With DEPTH=2: 2 entries accepted, then `if_ready_o=0`.
  - Slot payload is stable for all 6 cycles.
  - Order is preserved after release.
- **Load-use:** `ex_load_pending_i=1`, `ex_load_rd_i=5`, head ADD x3,x5,x6.
  - `ex_valid_o` stays 0 for 3 cycles.
  - `hazard_cnt_o=3`.
  - The instruction issues the cycle after pending drops.
  - Control case: with `ex_load_rd_i=0` there is no stall.
- **Bypass:** issue ADD x3,x7,x0 with `rs1_data_i=0x11`, `wb_en_i=1`, `wb_rd_i=7`, `wb_data_i=0xAA`.
  - `ex_rs1_data_o=0xAA`, `ex_rs2_data_o=0`.
- **Illegal decode:**
  - 0x00000013 is legal.
  - 0x00003003 (LD), 0x00003023 (SD) and 0x00000012 (bad LSBs) issue with `ex_illegal_o=1`.
- **Flush and reset:**
  - With the FIFO full and slot valid, pulse `flush_i` together with a push: the next cycle has count 0, `ex_valid_o=0`, and the pushed word is never issued.
  - Assert `rst_i` mid-stream: all outputs return to 0 after one edge.
